agc_multi_ctrl: RTL and testbench

Multi-channel AGC measurement sequencer in the aclk domain. It generates the accumulator tick and clock-enable shared by NCHAN agc_core instances and runs integration periods of programmable length, in single-shot or continuous mode. At the end of each period it captures every channel's square/greater-than/less-than accumulators into holding registers and flags completion, raising overrun when a capture lands before software acknowledged the previous one. Any clock-domain crossing to the bus side is done outside this block.

---
 rtl/agc_multi_ctrl_pkg.sv | 26 ++
 rtl/agc_multi_ctrl_if.sv | 41 ++++
 rtl/agc_multi_ctrl_timer.sv | 34 +++
 rtl/agc_multi_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_agc_multi_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_multi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// agc_ctrl_pkg
// Shared types and helpers for the multi-channel AGC measurement sequencer.
//   state_t    : sequencer states
//   DEF_*      : default accumulator widths
//   chan_lsb() : LSB position of a channel inside a packed per-channel bus
// -----------------------------------------------------------------------------
package agc_ctrl_pkg;

    localparam int DEF_SQ_BITS  = 25;
    localparam int DEF_CNT_BITS = 21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TICK,
        S_INTEGRATE,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    // Channel c of a bus packed as {.., ch1, ch0} starts at c*width.
    function automatic int chan_lsb(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/agc_multi_ctrl_if.sv
// -----------------------------------------------------------------------------
// agc_multi_ctrl_if
// Software-facing control/status/readout bundle of the AGC sequencer.
//   start_i/stop_i/cont_i/period_i/done_ack_i : run control (master -> slave)
//   rd_chan_i                                 : readout channel select
//   rd_sq_o/rd_gt_o/rd_lt_o                   : registered readout data
//   busy_o/done_o/overrun_o/capture_count_o   : status
// -----------------------------------------------------------------------------
interface agc_multi_ctrl_if #(
    parameter int NCHAN       = 8,
    parameter int SQ_BITS     = 25,
    parameter int CNT_BITS    = 21,
    parameter int PERIOD_BITS = 24
);
    localparam int RD_W = $clog2(NCHAN) + 1;

    logic                   start_i;
    logic                   stop_i;
    logic                   cont_i;
    logic [PERIOD_BITS-1:0] period_i;
    logic                   done_ack_i;
    logic [RD_W-1:0]        rd_chan_i;
    logic [SQ_BITS-1:0]     rd_sq_o;
    logic [CNT_BITS-1:0]    rd_gt_o;
    logic [CNT_BITS-1:0]    rd_lt_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   overrun_o;
    logic [15:0]            capture_count_o;

    modport master (
        output start_i, stop_i, cont_i, period_i, done_ack_i, rd_chan_i,
        input  rd_sq_o, rd_gt_o, rd_lt_o, busy_o, done_o, overrun_o, capture_count_o
    );

    modport slave (
        input  start_i, stop_i, cont_i, period_i, done_ack_i, rd_chan_i,
        output rd_sq_o, rd_gt_o, rd_lt_o, busy_o, done_o, overrun_o, capture_count_o
    );

endinterface

// File: rtl/agc_multi_ctrl_timer.sv
// -----------------------------------------------------------------------------
// agc_period_timer
// Loadable down-counter timing the integration and drain phases.
//   i_aclk, i_rst_n : clock, async active-low reset
//   i_load          : load i_load_val (has priority over i_ce)
//   i_ce            : count down by one (holds at zero)
//   o_tc            : terminal count, high while the count equals 1
// -----------------------------------------------------------------------------
module agc_period_timer #(
    parameter int PERIOD_BITS = 24
) (
    input  logic                   i_aclk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [PERIOD_BITS-1:0] i_load_val,
    input  logic                   i_ce,
    output logic                   o_tc
);
    logic [PERIOD_BITS-1:0] r_count;

    always_ff @(posedge i_aclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_ce && (r_count != '0)) begin
            r_count <= r_count - PERIOD_BITS'(1);
        end
    end

    // The last cycle of a phase is the one in which the count reads 1.
    assign o_tc = (r_count == PERIOD_BITS'(1));

endmodule

// File: rtl/agc_multi_ctrl.sv
// -----------------------------------------------------------------------------
// agc_multi_ctrl
// Multi-channel AGC measurement sequencer. Drives the shared tick/ce of the
// agc_core instances, times integration periods (single-shot or continuous),
// captures all channel accumulators at the end of each period and reports
// done/overrun/capture count.
//   aclk, aresetn          : clock, async active-low reset
//   ctrl (slave)           : run control, status and readout bundle
//   agc_tick_o, agc_ce_o   : accumulator reset pulse / accumulate enable
//   sq/gt/lt_accum_i       : packed per-channel accumulators from the cores
// -----------------------------------------------------------------------------
module agc_multi_ctrl
    import agc_ctrl_pkg::*;
#(
    parameter int NCHAN         = 8,
    parameter int SQ_BITS       = DEF_SQ_BITS,
    parameter int CNT_BITS      = DEF_CNT_BITS,
    parameter int PERIOD_BITS   = 24,
    parameter int CAPTURE_DELAY = 6
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    agc_multi_ctrl_if.slave           ctrl,
    output logic                      agc_tick_o,
    output logic                      agc_ce_o,
    input  logic [NCHAN*SQ_BITS-1:0]  sq_accum_i,
    input  logic [NCHAN*CNT_BITS-1:0] gt_accum_i,
    input  logic [NCHAN*CNT_BITS-1:0] lt_accum_i
);
    localparam int RD_W = $clog2(NCHAN) + 1;
    localparam logic [PERIOD_BITS-1:0] DELAY_VAL = PERIOD_BITS'(CAPTURE_DELAY);

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_cont;
    logic                   r_stop_pend;
    logic                   r_done;
    logic                   r_overrun;
    logic [15:0]            r_cap_count;
    logic                   w_start;
    logic                   w_tc;
    logic                   w_load;
    logic [PERIOD_BITS-1:0] w_load_val;
    logic [PERIOD_BITS-1:0] w_period_eff;

    logic [SQ_BITS-1:0]     r_sq [NCHAN];
    logic [CNT_BITS-1:0]    r_gt [NCHAN];
    logic [CNT_BITS-1:0]    r_lt [NCHAN];
    logic [SQ_BITS-1:0]     w_sq_sel;
    logic [CNT_BITS-1:0]    w_gt_sel;
    logic [CNT_BITS-1:0]    w_lt_sel;
    logic [SQ_BITS-1:0]     r_rd_sq;
    logic [CNT_BITS-1:0]    r_rd_gt;
    logic [CNT_BITS-1:0]    r_rd_lt;

    // Reset asserts immediately, releases two edges after aresetn rises.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_start      = ctrl.start_i && !ctrl.stop_i;
    assign w_period_eff = (ctrl.period_i == '0) ? PERIOD_BITS'(1) : ctrl.period_i;

    agc_period_timer #(.PERIOD_BITS(PERIOD_BITS)) u_timer (
        .i_aclk     (aclk),
        .i_rst_n    (w_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_ce       ((r_state == S_INTEGRATE) || (r_state == S_DRAIN)),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = w_period_eff;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_TICK;
            S_TICK: begin
                w_next = S_INTEGRATE;
                w_load = 1'b1;
            end
            S_INTEGRATE: if (w_tc) begin
                if (CAPTURE_DELAY == 0) begin
                    w_next = S_CAPTURE;
                end else begin
                    w_next     = S_DRAIN;
                    w_load     = 1'b1;
                    w_load_val = DELAY_VAL;
                end
            end
            S_DRAIN: if (w_tc) w_next = S_CAPTURE;
            // A stop arriving in the capture cycle itself still ends the run.
            S_CAPTURE: w_next = (r_cont && !(r_stop_pend || ctrl.stop_i)) ? S_TICK : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_cap_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_stop_pend <= 1'b0;
                if (w_start) begin
                    r_cont    <= ctrl.cont_i;
                    r_overrun <= 1'b0;
                end
            end else if (ctrl.stop_i && r_cont) begin
                r_stop_pend <= 1'b1;
            end
            // Capture beats a coincident acknowledge.
            if (r_state == S_CAPTURE) begin
                r_done      <= 1'b1;
                r_cap_count <= r_cap_count + 16'd1;
                if (r_done && !ctrl.done_ack_i) r_overrun <= 1'b1;
            end else if (ctrl.done_ack_i) begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_sq[c] <= '0;
                r_gt[c] <= '0;
                r_lt[c] <= '0;
            end
        end else if (r_state == S_CAPTURE) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_sq[c] <= sq_accum_i[chan_lsb(c, SQ_BITS)  +: SQ_BITS];
                r_gt[c] <= gt_accum_i[chan_lsb(c, CNT_BITS) +: CNT_BITS];
                r_lt[c] <= lt_accum_i[chan_lsb(c, CNT_BITS) +: CNT_BITS];
            end
        end
    end

    // Out-of-range channel selects match nothing and read as zero.
    always_comb begin
        w_sq_sel = '0;
        w_gt_sel = '0;
        w_lt_sel = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (ctrl.rd_chan_i == RD_W'(c)) begin
                w_sq_sel = r_sq[c];
                w_gt_sel = r_gt[c];
                w_lt_sel = r_lt[c];
            end
        end
    end

    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_sq <= '0;
            r_rd_gt <= '0;
            r_rd_lt <= '0;
        end else begin
            r_rd_sq <= w_sq_sel;
            r_rd_gt <= w_gt_sel;
            r_rd_lt <= w_lt_sel;
        end
    end

    assign agc_tick_o           = (r_state == S_TICK);
    assign agc_ce_o             = (r_state == S_INTEGRATE);
    assign ctrl.busy_o          = (r_state != S_IDLE);
    assign ctrl.done_o          = r_done;
    assign ctrl.overrun_o       = r_overrun;
    assign ctrl.capture_count_o = r_cap_count;
    assign ctrl.rd_sq_o         = r_rd_sq;
    assign ctrl.rd_gt_o         = r_rd_gt;
    assign ctrl.rd_lt_o         = r_rd_lt;

endmodule

// File: tb/tb_agc_multi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_agc_multi_ctrl
// Bench for agc_multi_ctrl: a period-offset reference model tracks the
// expected outputs every cycle, and directed scenarios pin literal timings.
// -----------------------------------------------------------------------------
module tb_agc_multi_ctrl;
    localparam int NCH = 8;
    localparam int SQB = 25;
    localparam int CNB = 21;
    localparam int PB  = 24;
    localparam int DLY = 6;

    logic aclk = 1'b0;
    logic aresetn;
    logic tick, ce;
    logic [NCH*SQB-1:0] sq_acc = '0;
    logic [NCH*CNB-1:0] gt_acc = '0;
    logic [NCH*CNB-1:0] lt_acc = '0;
    logic rand_acc = 1'b0;
    logic chk_on   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit             m_run, m_cont, m_pend, m_done, m_ovr;
    int             m_off, m_p, m_hold;
    logic [15:0]    m_caps;
    logic [15:0]    m_base = '0;
    logic [SQB-1:0] m_sq [NCH];
    logic [CNB-1:0] m_gt [NCH];
    logic [CNB-1:0] m_lt [NCH];
    logic [SQB-1:0] m_rd_sq;
    logic [CNB-1:0] m_rd_gt, m_rd_lt;

    always #5 aclk = ~aclk;

    agc_multi_ctrl_if #(.NCHAN(NCH), .SQ_BITS(SQB), .CNT_BITS(CNB), .PERIOD_BITS(PB)) bus ();

    agc_multi_ctrl #(
        .NCHAN(NCH), .SQ_BITS(SQB), .CNT_BITS(CNB), .PERIOD_BITS(PB), .CAPTURE_DELAY(DLY)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .ctrl       (bus),
        .agc_tick_o (tick),
        .agc_ce_o   (ce),
        .sq_accum_i (sq_acc),
        .gt_accum_i (gt_acc),
        .lt_accum_i (lt_acc)
    );

    // Model: each period is tick (offset 0), P accumulate cycles, DLY drain
    // cycles and one capture cycle at offset P+1+DLY.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_run = 0; m_cont = 0; m_pend = 0; m_done = 0; m_ovr = 0;
            m_off = 0; m_p = 1; m_hold = 2; m_caps = '0;
            m_rd_sq = '0; m_rd_gt = '0; m_rd_lt = '0;
            for (int c = 0; c < NCH; c++) begin
                m_sq[c] = '0; m_gt[c] = '0; m_lt[c] = '0;
            end
        end else begin
            if (bus.rd_chan_i < 4'd8) begin
                m_rd_sq = m_sq[bus.rd_chan_i[2:0]];
                m_rd_gt = m_gt[bus.rd_chan_i[2:0]];
                m_rd_lt = m_lt[bus.rd_chan_i[2:0]];
            end else begin
                m_rd_sq = '0; m_rd_gt = '0; m_rd_lt = '0;
            end
            if (m_hold > 0) begin
                m_hold = m_hold - 1;
            end else if (!m_run) begin
                if (bus.done_ack_i) m_done = 0;
                if (bus.start_i && !bus.stop_i) begin
                    m_run = 1; m_off = 0; m_cont = bus.cont_i; m_pend = 0; m_ovr = 0;
                end
            end else begin
                if (bus.stop_i && m_cont) m_pend = 1;
                if (m_off == 0) m_p = (bus.period_i == '0) ? 1 : int'(bus.period_i);
                if (m_off == m_p + 1 + DLY) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_sq[c] = sq_acc[c*SQB +: SQB];
                        m_gt[c] = gt_acc[c*CNB +: CNB];
                        m_lt[c] = lt_acc[c*CNB +: CNB];
                    end
                    if (m_done && !bus.done_ack_i) m_ovr = 1;
                    m_done = 1;
                    m_caps = m_caps + 16'd1;
                    if (m_cont && !m_pend) m_off = 0;
                    else begin m_run = 0; m_pend = 0; end
                end else begin
                    m_off = m_off + 1;
                    if (bus.done_ack_i) m_done = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge aclk);
            if (rand_acc) begin
                for (int c = 0; c < NCH; c++) begin
                    sq_acc[c*SQB +: SQB] = SQB'($urandom);
                    gt_acc[c*CNB +: CNB] = CNB'($urandom);
                    lt_acc[c*CNB +: CNB] = CNB'($urandom);
                end
            end
        end
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (bus.busy_o && k < lim) begin cyc(1); k++; end
        if (bus.busy_o) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_ack();
        bus.done_ack_i = 1'b1; cyc(1); bus.done_ack_i = 1'b0; cyc(1);
    endtask

    initial begin
        int first_tick, first_ce, last_ce, n_ce, first_done, busy25;
        int ticks[$];

        bus.start_i = 0; bus.stop_i = 0; bus.cont_i = 0; bus.period_i = '0;
        bus.done_ack_i = 0; bus.rd_chan_i = '0;
        aresetn = 1'b1;
        #3 aresetn = 1'b0;

        fork
            forever begin
                @(negedge aclk);
                if (chk_on) begin
                    check("tick",    32'(tick),                 32'(m_run && m_off == 0));
                    check("ce",      32'(ce),                   32'(m_run && m_off >= 1 && m_off <= m_p));
                    check("busy",    32'(bus.busy_o),           32'(m_run));
                    check("done",    32'(bus.done_o),           32'(m_done));
                    check("overrun", 32'(bus.overrun_o),        32'(m_ovr));
                    check("count",   32'(bus.capture_count_o),  32'(16'(m_base + m_caps)));
                    check("rd_sq",   32'(bus.rd_sq_o),          32'(m_rd_sq));
                    check("rd_gt",   32'(bus.rd_gt_o),          32'(m_rd_gt));
                    check("rd_lt",   32'(bus.rd_lt_o),          32'(m_rd_lt));
                end
            end
        join_none

        cyc(3);
        aresetn = 1'b1;
        cyc(3);
        chk_on = 1'b1;
        check("rst_busy",  32'(bus.busy_o), 0);
        check("rst_done",  32'(bus.done_o), 0);
        check("rst_ovr",   32'(bus.overrun_o), 0);
        check("rst_count", 32'(bus.capture_count_o), 0);
        check("rst_tick",  32'(tick), 0);
        check("rst_ce",    32'(ce), 0);
        check("rst_rd_sq", 32'(bus.rd_sq_o), 0);

        // Single-shot, P=16, ramp inputs
        for (int c = 0; c < NCH; c++) begin
            sq_acc[c*SQB +: SQB] = SQB'(100 + c);
            gt_acc[c*CNB +: CNB] = CNB'(200 + c);
            lt_acc[c*CNB +: CNB] = CNB'(300 + c);
        end
        bus.rd_chan_i = 4'd3; bus.period_i = 24'd16; bus.cont_i = 0;
        first_tick = -1; first_ce = -1; last_ce = -1; n_ce = 0; first_done = -1; busy25 = -1;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        for (int i = 1; i <= 30; i++) begin
            if (tick && first_tick < 0) first_tick = i;
            if (ce) begin if (first_ce < 0) first_ce = i; last_ce = i; n_ce++; end
            if (bus.done_o && first_done < 0) first_done = i;
            if (i == 25) busy25 = int'(bus.busy_o);
            cyc(1);
        end
        check("t1_tick_cyc",  32'(first_tick), 1);
        check("t1_ce_first",  32'(first_ce), 2);
        check("t1_ce_last",   32'(last_ce), 17);
        check("t1_ce_count",  32'(n_ce), 16);
        check("t1_done_cyc",  32'(first_done), 25);
        check("t1_busy25",    32'(busy25), 0);
        check("t1_count",     32'(bus.capture_count_o), 1);
        check("t1_rd_sq3",    32'(bus.rd_sq_o), 103);
        check("t1_rd_gt3",    32'(bus.rd_gt_o), 203);
        check("t1_rd_lt3",    32'(bus.rd_lt_o), 303);
        for (int c = 0; c < NCH; c++) begin
            bus.rd_chan_i = 4'(c); cyc(1);
            check("t1_rd_ramp", 32'(bus.rd_sq_o), 32'(100 + c));
        end

        // Continuous, P=4, no ack, stop in third period
        rand_acc = 1'b1;
        pulse_ack();
        bus.period_i = 24'd4; bus.cont_i = 1;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        for (int i = 1; i <= 40; i++) begin
            bus.rd_chan_i = 4'($urandom_range(0, 15));
            if (tick) ticks.push_back(i);
            if (i == 13) begin
                check("t2_ovr13", 32'(bus.overrun_o), 0);
                check("t2_cnt13", 32'(bus.capture_count_o), 2);
            end
            if (i == 25) begin
                check("t2_ovr25", 32'(bus.overrun_o), 1);
                check("t2_cnt25", 32'(bus.capture_count_o), 3);
            end
            bus.stop_i = (i == 28);
            cyc(1);
        end
        bus.stop_i = 0;
        check("t2_nticks", 32'(ticks.size()), 3);
        if (ticks.size() == 3) begin
            check("t2_tick0", 32'(ticks[0]), 1);
            check("t2_tick1", 32'(ticks[1]), 13);
            check("t2_tick2", 32'(ticks[2]), 25);
        end
        check("t2_busy_end", 32'(bus.busy_o), 0);
        check("t2_cnt_end",  32'(bus.capture_count_o), 4);

        // Period 0 behaves as 1; out-of-range readout
        pulse_ack();
        bus.period_i = '0; bus.cont_i = 0;
        n_ce = 0;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        for (int i = 1; i <= 12; i++) begin
            if (ce) n_ce++;
            cyc(1);
        end
        check("t3_ce_count", 32'(n_ce), 1);
        wait_idle(100);
        bus.rd_chan_i = 4'd9; cyc(2);
        check("t3_rd9_sq", 32'(bus.rd_sq_o), 0);
        check("t3_rd9_gt", 32'(bus.rd_gt_o), 0);
        check("t3_rd9_lt", 32'(bus.rd_lt_o), 0);

        // Ack coinciding with capture; start while busy
        pulse_ack();
        bus.period_i = 24'd4; bus.cont_i = 1;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        for (int i = 1; i <= 45; i++) begin
            bus.rd_chan_i = 4'($urandom_range(0, 15));
            bus.start_i    = (i == 5);
            bus.cont_i     = (i == 5) ? 1'b0 : 1'b1;
            bus.done_ack_i = (i == 24);
            bus.stop_i     = (i == 26);
            if (i == 25) begin
                check("t4_done_kept", 32'(bus.done_o), 1);
                check("t4_no_ovr",    32'(bus.overrun_o), 0);
            end
            cyc(1);
        end
        bus.start_i = 0; bus.done_ack_i = 0; bus.stop_i = 0;
        wait_idle(100);
        bus.start_i = 1; bus.stop_i = 1; cyc(1);
        bus.start_i = 0; bus.stop_i = 0; cyc(2);
        check("t4_startstop", 32'(bus.busy_o), 0);

        // Reset during integration
        bus.period_i = 24'd16; bus.cont_i = 0; bus.rd_chan_i = 4'd2;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        cyc(4);
        check("t5_ce_before", 32'(ce), 1);
        #2 aresetn = 1'b0;
        #1;
        check("t5_ce_async",  32'(ce), 0);
        check("t5_tick",      32'(tick), 0);
        check("t5_busy",      32'(bus.busy_o), 0);
        check("t5_done",      32'(bus.done_o), 0);
        check("t5_count",     32'(bus.capture_count_o), 0);
        cyc(1);
        aresetn = 1'b1;
        cyc(3);
        check("t5_rd_zero", 32'(bus.rd_sq_o), 0);
        bus.period_i = 24'd3;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        cyc(2);
        wait_idle(100);
        cyc(1);
        check("t5_rerun_cnt",  32'(bus.capture_count_o), 1);
        check("t5_rerun_done", 32'(bus.done_o), 1);

        // Capture counter wrap
        @(posedge aclk); #1;
        force dut.r_cap_count = 16'hFFFF;
        m_base = 16'hFFFF - m_caps;
        cyc(1);
        release dut.r_cap_count;
        cyc(1);
        check("t6_preload", 32'(bus.capture_count_o), 32'hFFFF);
        bus.period_i = 24'd1;
        bus.start_i = 1; cyc(1); bus.start_i = 0;
        cyc(2);
        wait_idle(100);
        cyc(1);
        check("t6_wrap", 32'(bus.capture_count_o), 0);

        chk_on = 1'b0;
        cyc(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
